// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch controller.
// S_HALT exists only when PC_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INST_W_DEF  = 32;
    localparam int PC_STEP_DEF = 4;

    // Low PC bits that must be zero for an aligned fetch.
    localparam int                    ALIGN_BITS    = 2;
    localparam logic [ALIGN_BITS-1:0] ALIGN_LO_MASK = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
`ifdef PC_MISALIGN_TRAP_EN
        S_DROP,
        S_HALT
`else
        S_DROP
`endif
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus plus the decode-side
// valid/ready output bundle of the fetch controller.
interface pc_fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
);

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   inst_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst_out, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst_out, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready buffer holding a fetched word and its PC.
// Flush beats load, load beats pop.
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              pop_i,
    input  logic [INST_W-1:0] data_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              valid_o,
    output logic [INST_W-1:0] data_o,
    output logic [PC_W-1:0]   pc_o
);

    logic              valid_q, valid_d;
    logic [INST_W-1:0] data_q, data_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Next-PC generation and imem request/response sequencing.
// PC_MISALIGN_TRAP_EN adds fetch_misalign and the S_HALT trap state.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int INST_W  = INST_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_in,
    output logic [PC_W-1:0] pc_next,
    output logic            pc_ena,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_target,
`ifdef PC_MISALIGN_TRAP_EN
    output logic            fetch_misalign,
`endif
    pc_fetch_ctrl_if.master bus
);

    localparam logic [PC_W-1:0] PC_MASK =
        ~{{(PC_W-ALIGN_BITS){1'b0}}, ALIGN_LO_MASK};

    fetch_state_e    state_q, state_d;
    logic            buf_free;
    logic            req;
    logic            granted;
    logic            accept;
    logic            redir_take;
    logic            halt_pend;
    logic            pending;
    logic [PC_W-1:0] redir_pc;

    assign pending = state_q == S_WAIT || state_q == S_DROP;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic misaligned;
    logic outstanding;

    assign misaligned  = |(redir_target & ~PC_MASK);
    assign halt_pend   = misalign_q;
    assign redir_pc    = misaligned ? redir_target
                                    : redir_target & PC_MASK;
    // A fetch still owed by memory after this edge forces a detour via S_DROP.
    assign outstanding = granted || (pending && !bus.imem_rvalid);
    assign misalign_d  = misalign_q | (redir_take & misaligned);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign fetch_misalign = misalign_q;
`else
    assign halt_pend = 1'b0;
    assign redir_pc  = redir_target & PC_MASK;
`endif

    assign redir_take = redir_valid && !halt_pend
                     && (state_q == S_REQ || pending);
    assign buf_free   = !bus.inst_valid || bus.inst_ready;
    assign req        = (state_q == S_REQ) && buf_free;
    assign granted    = req && bus.imem_gnt;
    assign accept     = (state_q == S_WAIT) && bus.imem_rvalid
                     && !redir_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (granted) state_d = redir_take ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) state_d = S_REQ;
                else if (redir_take) state_d = S_DROP;
            end
            S_DROP: begin
                if (bus.imem_rvalid) state_d = halt_pend ? S_DROP : S_REQ;
`ifdef PC_MISALIGN_TRAP_EN
                if (bus.imem_rvalid && halt_pend) state_d = S_HALT;
`endif
            end
`ifdef PC_MISALIGN_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        if (redir_take && misaligned) begin
            state_d = outstanding ? S_DROP : S_HALT;
        end
`endif
    end

    always_comb begin
        pc_ena  = 1'b0;
        pc_next = '0;
        if (redir_take) begin
            pc_ena  = 1'b1;
            pc_next = redir_pc;
        end else if (accept) begin
            pc_ena  = 1'b1;
            pc_next = pc_in + PC_W'(PC_STEP);
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = req ? pc_in : '0;

    fetch_out_buf #(
        .INST_W (INST_W),
        .PC_W   (PC_W)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .flush_i (redir_take),
        .pop_i   (bus.inst_valid && bus.inst_ready),
        .data_i  (bus.imem_rdata),
        .pc_i    (pc_in),
        .valid_o (bus.inst_valid),
        .data_o  (bus.inst_out),
        .pc_o    (bus.inst_pc)
    );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: PC register and imem models, a flag-based
// behavioural reference checked every cycle, plus directed literal checks.
module tb_pc_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
`ifdef PC_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    logic        inst_ready = 1'b1;
    logic        gnt_en = 1'b1;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] rdata_q = '0;
    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int passed = 0;
    int n;
    bit found;
    logic [31:0] ena_q [$];

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.PC_W(32), .INST_W(32)) bus();

    assign bus.imem_gnt    = bus.imem_req & gnt_en;
    assign bus.imem_rvalid = (cnt == 1);
    assign bus.imem_rdata  = rdata_q;
    assign bus.inst_ready  = inst_ready;

    pc_fetch_ctrl #(.INST_W(32), .PC_W(32), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_reg),
        .pc_next        (pc_next),
        .pc_ena         (pc_ena),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
`ifdef PC_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
`endif
        .bus            (bus)
    );

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= '0;
        else if (pc_ena) pc_reg <= pc_next;
    end

    // Memory: grant when enabled, one response lat cycles after grant.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 0;
        end else begin
            if (cnt != 0) cnt <= cnt - 1;
            if (bus.imem_req && bus.imem_gnt) begin
                cnt     <= lat;
                rdata_q <= memrd(bus.imem_addr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                      nm, act, exp, $time);
    endtask

    // Reference model: outstanding/discard flags and a buffer image.
    bit          m_started, m_out, m_disc, m_bv, m_halt;
    logic [31:0] m_bd, m_bp;

    always @(negedge clk) begin
        bit          eff, mis, ereq, resp, acc, grant, out_n;
        logic [31:0] enext;
        if (rst) begin
            m_started = 0; m_out = 0; m_disc = 0;
            m_bv = 0; m_halt = 0; m_bd = '0; m_bp = '0;
            chk("rst_req", bus.imem_req, 0);
            chk("rst_ena", pc_ena, 0);
            chk("rst_next", pc_next, 0);
            chk("rst_valid", bus.inst_valid, 0);
            chk("rst_out", bus.inst_out, 0);
            chk("rst_pc", bus.inst_pc, 0);
`ifdef PC_MISALIGN_TRAP_EN
            chk("rst_misalign", fetch_misalign, 0);
`endif
        end else begin
            mis = 0;
`ifdef PC_MISALIGN_TRAP_EN
            mis = redir_target[1:0] != 2'b00;
`endif
            eff   = redir_valid && m_started && !m_halt;
            ereq  = m_started && !m_out && !m_halt
                 && (!m_bv || inst_ready);
            resp  = bus.imem_rvalid && m_out;
            acc   = resp && !m_disc && !eff;
            enext = pc_reg + 32'd4;
            if (eff) enext = mis ? redir_target
                                 : {redir_target[31:2], 2'b00};
            chk("req", bus.imem_req, ereq);
            if (ereq) chk("addr", bus.imem_addr, pc_reg);
            chk("pc_ena", pc_ena, eff || acc);
            if (eff || acc) chk("pc_next", pc_next, enext);
            chk("inst_valid", bus.inst_valid, m_bv);
            if (m_bv) begin
                chk("inst_out", bus.inst_out, m_bd);
                chk("inst_pc", bus.inst_pc, m_bp);
            end
`ifdef PC_MISALIGN_TRAP_EN
            chk("misalign", fetch_misalign, m_halt);
`endif
            grant = ereq && bus.imem_gnt;
            if (eff) m_bv = 0;
            else if (acc) begin
                m_bv = 1; m_bd = bus.imem_rdata; m_bp = pc_reg;
            end else if (m_bv && inst_ready) m_bv = 0;
            out_n = grant ? 1'b1 : (resp ? 1'b0 : m_out);
            if (eff) m_disc = out_n;
            else if (resp) m_disc = 0;
            m_out = out_n;
            if (eff && mis) m_halt = 1;
            m_started = 1;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        redir_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (pc_ena) ena_q.push_back(pc_next);
            if (bus.inst_valid) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mem[32'h0] = 32'h1111_1111;
        mem[32'h4] = 32'h2222_2222;
        mem[32'h8] = 32'h3333_3333;

        // Back-to-back fetch with 1-cycle memory.
        inst_ready = 1; lat = 1;
        do_reset();
        ena_q.delete();
        wait_valid(n);
        chk("t1_latency", n, 3);
        chk("t1_word0", bus.inst_out, 32'h1111_1111);
        chk("t1_pc0", bus.inst_pc, 32'h0);
        chk("t1_ena_cnt0", ena_q.size(), 1);
        if (ena_q.size() > 0) chk("t1_next0", ena_q[0], 32'h4);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (pc_ena) ena_q.push_back(pc_next);
        end
        chk("t1_word1", bus.inst_out, 32'h2222_2222);
        chk("t1_pc1", bus.inst_pc, 32'h4);
        chk("t1_ena_cnt1", ena_q.size(), 2);
        if (ena_q.size() > 1) chk("t1_next1", ena_q[1], 32'h8);

        // Decode stalls: no request while the buffer is full.
        inst_ready = 0;
        do_reset();
        wait_valid(n);
        chk("t2_latency", n, 3);
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            chk("t2_noreq", bus.imem_req, 0);
            chk("t2_hold", bus.inst_out, 32'h1111_1111);
        end
        @(posedge clk); #1 inst_ready = 1;
        @(negedge clk);
        chk("t2_req", bus.imem_req, 1);
        chk("t2_addr", bus.imem_addr, 32'h4);
        repeat (4) @(posedge clk);

        // Redirect while waiting on a slow response.
        lat = 4;
        mem[32'h0] = 32'hDEAD_BEEF;
        do_reset();
        repeat (2) @(posedge clk);
        #1 redir_valid = 1; redir_target = 32'h100;
        @(negedge clk);
        chk("t3_ena", pc_ena, 1);
        chk("t3_next", pc_next, 32'h100);
        @(posedge clk); #1 redir_valid = 0;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                found = 1;
                chk("t3_addr", bus.imem_addr, 32'h100);
                break;
            end
            chk("t3_flushed", bus.inst_valid, 0);
            @(posedge clk); #1;
        end
        chk("t3_found", found, 1);
        lat = 1;
        repeat (8) @(posedge clk);

        // PC wrap at the top of the address space.
        do_reset();
        @(posedge clk);
        #1 redir_valid = 1; redir_target = 32'hFFFF_FFFC;
        @(posedge clk); #1 redir_valid = 0;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pc_ena) begin
                found = 1;
                chk("t4_wrap", pc_next, 32'h0);
                break;
            end
            @(posedge clk); #1;
        end
        chk("t4_found", found, 1);
        @(posedge clk); @(negedge clk);
        chk("t4_pc", bus.inst_pc, 32'hFFFF_FFFC);
        repeat (3) @(posedge clk);

        // Redirect coinciding with rvalid discards the word.
        do_reset();
        repeat (2) @(posedge clk);
        #1 redir_valid = 1; redir_target = 32'h40;
        @(negedge clk);
        chk("t7_ena", pc_ena, 1);
        chk("t7_next", pc_next, 32'h40);
        @(posedge clk); #1 redir_valid = 0;
        @(negedge clk);
        chk("t7_valid", bus.inst_valid, 0);
        chk("t7_req", bus.imem_req, 1);
        chk("t7_addr", bus.imem_addr, 32'h40);
        repeat (3) @(posedge clk);

        // Misaligned redirect target.
        do_reset();
        @(posedge clk);
        #1 redir_valid = 1; redir_target = 32'h103;
        @(negedge clk);
        chk("t5_ena", pc_ena, 1);
`ifdef PC_MISALIGN_TRAP_EN
        chk("t5_next", pc_next, 32'h103);
        @(posedge clk); #1 redir_valid = 0;
        for (int i = 0; i < 10; i++) begin
            redir_valid = (i == 5);
            redir_target = 32'h200;
            @(negedge clk);
            chk("t5_halt_req", bus.imem_req, 0);
            chk("t5_flag", fetch_misalign, 1);
            chk("t5_halt_ena", pc_ena, 0);
            @(posedge clk); #1;
        end
        redir_valid = 0;
`else
        chk("t5_next", pc_next, 32'h100);
        @(posedge clk); #1 redir_valid = 0;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                found = 1;
                chk("t5_addr", bus.imem_addr, 32'h100);
                break;
            end
            @(posedge clk); #1;
        end
        chk("t5_found", found, 1);
`endif

        // Reset asserted while a fetch is outstanding.
        lat = 3;
        do_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("t6_valid", bus.inst_valid, 0);
        chk("t6_ena", pc_ena, 0);
        chk("t6_req", bus.imem_req, 0);
        chk("t6_state", 32'(dut.state_q), 32'(S_IDLE));
        @(posedge clk); #1 rst = 0;
        lat = 1;
        wait_valid(n);
        chk("t6_restart", n, 3);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
